// File: rtl/tia_hsync_decoder_pkg.sv
// Shared types and LFSR helpers for the TIA horizontal-sync decoder.
// Holds the FSM state encoding, default line thresholds and the LFSR code helpers.
package tia_hsync_decoder_pkg;

    localparam int unsigned DEF_LINE_COUNTS = 57;
    localparam int unsigned DEF_SHS_CNT     = 4;
    localparam int unsigned DEF_RHS_CNT     = 8;
    localparam int unsigned DEF_CB_CNT      = 12;
    localparam int unsigned DEF_RCB_CNT     = 16;
    localparam int unsigned DEF_LRHB_CNT    = 18;

    typedef enum logic [2:0] {
        ST_BLANK,
        ST_SYNC,
        ST_BURST,
        ST_POSTCB,
        ST_LATEHB,
        ST_ACTIVE
    } hstate_t;

    function automatic logic [5:0] lfsr_next(input logic [5:0] cur);
        return {cur[1] ^ ~cur[0], cur[5:1]};
    endfunction

    // LFSR state reached after k steps from 000000
    function automatic logic [5:0] lfsr_code(input int unsigned k);
        logic [5:0] cur;
        cur = '0;
        for (int unsigned i = 0; i < k; i++) cur = lfsr_next(cur);
        return cur;
    endfunction

    function automatic logic code_valid(input logic [5:0] code, input int unsigned n);
        logic [5:0] cur;
        logic       hit;
        cur = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (code == cur) hit = 1'b1;
            cur = lfsr_next(cur);
        end
        return hit;
    endfunction

endpackage

// File: rtl/tia_lfsr_to_count.sv
// Combinational lookup from a 6-bit horizontal LFSR code to {valid, binary count}.
module tia_lfsr_to_count
    import tia_hsync_decoder_pkg::*;
#(
    parameter int unsigned LINE_COUNTS = DEF_LINE_COUNTS
) (
    input  logic [5:0] code,
    output logic       valid,
    output logic [5:0] count
);

    logic [5:0] cur;

    always_comb begin
        valid = 1'b0;
        count = '0;
        cur   = '0;
        for (int unsigned i = 0; i < LINE_COUNTS; i++) begin
            if (!valid && code == cur) begin
                valid = 1'b1;
                count = i[5:0];
            end
            cur = lfsr_next(cur);
        end
    end

endmodule

// File: rtl/tia_hsync_decoder.sv
// Decodes the horizontal LFSR into HBLANK/HSYNC/colour-burst and the end-of-line wrap request.
// Define TIA_HDEC_BINCOUNT_EN to build the binary encoder and drive hcount.
module tia_hsync_decoder
    import tia_hsync_decoder_pkg::*;
#(
    parameter int unsigned LINE_COUNTS = DEF_LINE_COUNTS,
    parameter int unsigned SHS_CNT     = DEF_SHS_CNT,
    parameter int unsigned RHS_CNT     = DEF_RHS_CNT,
    parameter int unsigned CB_CNT      = DEF_CB_CNT,
    parameter int unsigned RCB_CNT     = DEF_RCB_CNT,
    parameter int unsigned LRHB_CNT    = DEF_LRHB_CNT
) (
    input  logic       s1,
    input  logic       s2,
    input  logic       reset,
    input  logic [5:0] lfsr_in,
    input  logic       hmove,
    output logic       hblank,
    output logic       hsync,
    output logic       cburst,
    output logic       wrap,
    output logic       lfsr_err,
    output logic [5:0] hcount
);

    localparam logic [5:0] C_ZERO = lfsr_code(0);
    localparam logic [5:0] C_SHS  = lfsr_code(SHS_CNT);
    localparam logic [5:0] C_RHS  = lfsr_code(RHS_CNT);
    localparam logic [5:0] C_CB   = lfsr_code(CB_CNT);
    localparam logic [5:0] C_RCB  = lfsr_code(RCB_CNT);
    localparam logic [5:0] C_LRHB = lfsr_code(LRHB_CNT);
    localparam logic [5:0] C_LAST = lfsr_code(LINE_COUNTS - 1);

    logic [5:0] lat_code;
    logic       lat_hm;
    logic       code_ok;
    logic [5:0] hcount_src;

    always_ff @(posedge s1 or posedge reset) begin
        if (reset) begin
            lat_code <= '0;
            lat_hm   <= 1'b0;
        end else begin
            lat_code <= lfsr_in;
            lat_hm   <= hmove;
        end
    end

`ifdef TIA_HDEC_BINCOUNT_EN
    tia_lfsr_to_count #(.LINE_COUNTS(LINE_COUNTS)) u_lfsr_to_count (
        .code  (lat_code),
        .valid (code_ok),
        .count (hcount_src)
    );
`else
    assign code_ok    = code_valid(lat_code, LINE_COUNTS);
    assign hcount_src = '0;
`endif

    hstate_t    state, state_nx;
    logic       late_hb, late_nx;
    logic       hm_pend, pend_nx;
    logic       hblank_nx, hsync_nx, cburst_nx, wrap_nx, err_nx;
    logic [5:0] hcount_nx;

    always_ff @(posedge s2 or posedge reset) begin
        if (reset) begin
            state    <= ST_BLANK;
            late_hb  <= 1'b0;
            hm_pend  <= 1'b0;
            hblank   <= 1'b1;
            hsync    <= 1'b0;
            cburst   <= 1'b0;
            wrap     <= 1'b0;
            lfsr_err <= 1'b0;
            hcount   <= '0;
        end else begin
            state    <= state_nx;
            late_hb  <= late_nx;
            hm_pend  <= pend_nx;
            hblank   <= hblank_nx;
            hsync    <= hsync_nx;
            cburst   <= cburst_nx;
            wrap     <= wrap_nx;
            lfsr_err <= err_nx;
            hcount   <= hcount_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        late_nx   = late_hb;
        pend_nx   = hm_pend;
        hblank_nx = hblank;
        hsync_nx  = hsync;
        cburst_nx = cburst;
        wrap_nx   = wrap;
        err_nx    = lfsr_err;
        hcount_nx = hcount;
        if (!code_ok) begin
            err_nx = 1'b1;
        end else begin
            wrap_nx   = (lat_code == C_LAST);
            hcount_nx = hcount_src;
            // hm_pend carries an HMOVE seen anywhere in a line across the wrap into late_hb
            if (lat_code == C_ZERO) begin
                late_nx = hm_pend | lat_hm;
                pend_nx = 1'b0;
            end else if (lat_hm) begin
                late_nx = 1'b1;
                pend_nx = 1'b1;
            end
            if (lat_code == C_ZERO) begin
                state_nx  = ST_BLANK;
                hblank_nx = 1'b1;
                hsync_nx  = 1'b0;
                cburst_nx = 1'b0;
            end else begin
                unique case (state)
                    ST_BLANK:  if (lat_code == C_SHS) begin
                                   state_nx = ST_SYNC;
                                   hsync_nx = 1'b1;
                               end
                    ST_SYNC:   if (lat_code == C_RHS) begin
                                   state_nx = ST_BURST;
                                   hsync_nx = 1'b0;
                               end
                    ST_BURST:  if (lat_code == C_CB) begin
                                   state_nx  = ST_POSTCB;
                                   cburst_nx = 1'b1;
                               end
                    ST_POSTCB: if (lat_code == C_RCB) begin
                                   cburst_nx = 1'b0;
                                   if (late_hb) begin
                                       state_nx = ST_LATEHB;
                                   end else begin
                                       state_nx  = ST_ACTIVE;
                                       hblank_nx = 1'b0;
                                   end
                               end
                    ST_LATEHB: if (lat_code == C_LRHB) begin
                                   state_nx  = ST_ACTIVE;
                                   hblank_nx = 1'b0;
                               end
                    ST_ACTIVE: state_nx = ST_ACTIVE;
                    default:   state_nx = ST_BLANK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tia_hsync_decoder.sv
// Directed bench for tia_hsync_decoder with a queue scoreboard of expected output vectors.
module tb_tia_hsync_decoder;

    logic       s1, s2, reset, hmove;
    logic [5:0] lfsr_in;
    logic       hblank, hsync, cburst, wrap, lfsr_err;
    logic [5:0] hcount;

    tia_hsync_decoder dut (
        .s1(s1), .s2(s2), .reset(reset), .lfsr_in(lfsr_in), .hmove(hmove),
        .hblank(hblank), .hsync(hsync), .cburst(cburst), .wrap(wrap),
        .lfsr_err(lfsr_err), .hcount(hcount)
    );

`ifdef TIA_HDEC_BINCOUNT_EN
    localparam bit BIN = 1'b1;
`else
    localparam bit BIN = 1'b0;
`endif

    initial begin
        s1 = 1'b0;
        s2 = 1'b0;
        forever begin
            #5 s1 = 1'b1;
            #5 s1 = 1'b0;
            #5 s2 = 1'b1;
            #5 s2 = 1'b0;
        end
    end

    logic [5:0]  seq [57];
    logic [10:0] exp_q [$];
    string       tag_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        m_late, m_next_late, m_err;
    logic [10:0] m_last;
    logic [5:0]  bad_code;

    function automatic logic [10:0] model_vec(input int k, input logic late, input logic err);
        logic hb, hs, cb, wr;
        logic [5:0] hc;
        hb = (k < (late ? 18 : 16));
        hs = (k >= 4 && k < 8);
        cb = (k >= 12 && k < 16);
        wr = (k == 56);
        hc = BIN ? 6'(k) : 6'd0;
        return {hb, hs, cb, wr, err, hc};
    endfunction

    task automatic check_out();
        logic [10:0] obs, exp;
        string tag;
        obs = {hblank, hsync, cburst, wrap, lfsr_err, hcount};
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            n_assert++;
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic step(input int k, input logic hm);
        lfsr_in = seq[k];
        hmove   = hm;
        if (k == 0) begin
            m_late      = m_next_late | hm;
            m_next_late = 1'b0;
        end else if (hm) begin
            m_next_late = 1'b1;
        end
        m_last = model_vec(k, m_late, m_err);
        exp_q.push_back(m_last);
        tag_q.push_back($sformatf("count%0d", k));
        @(posedge s1);
        @(posedge s2);
        #1;
        check_out();
    endtask

    task automatic step_bad(input logic [5:0] code);
        lfsr_in = code;
        hmove   = 1'b0;
        m_err   = 1'b1;
        m_last[6] = 1'b1;
        exp_q.push_back(m_last);
        tag_q.push_back("invalid_code");
        @(posedge s1);
        @(posedge s2);
        #1;
        check_out();
    endtask

    task automatic run(input int from, input int to, input int hm_at);
        for (int k = from; k <= to; k++) step(k, k == hm_at);
    endtask

    task automatic reset_model();
        m_late      = 1'b0;
        m_next_late = 1'b0;
        m_err       = 1'b0;
        m_last      = {1'b1, 4'b0000, 6'd0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] cur;
        logic found, inseq;
        cur = '0;
        for (int i = 0; i < 57; i++) begin
            seq[i] = cur;
            cur = {cur[1] ^ ~cur[0], cur[5:1]};
        end
        found = 1'b0;
        bad_code = '0;
        for (int c = 0; c < 64; c++) begin
            inseq = 1'b0;
            for (int i = 0; i < 57; i++) if (seq[i] == 6'(c)) inseq = 1'b1;
            if (!inseq && !found) begin
                bad_code = 6'(c);
                found = 1'b1;
            end
        end

        reset   = 1'b1;
        lfsr_in = '0;
        hmove   = 1'b0;
        reset_model();
        #1;
        exp_q.push_back(m_last);
        tag_q.push_back("reset_state");
        check_out();
        #10 reset = 1'b0;
        @(posedge s2);
        #1;

        run(0, 56, -1);
        run(0, 56, 30);
        run(0, 56, -1);
        run(0, 56, -1);

        run(0, 9, -1);
        step_bad(bad_code);
        run(11, 20, -1);

        reset = 1'b1;
        reset_model();
        #1;
        reset = 1'b0;
        @(posedge s2);
        #1;
        run(0, 6, -1);
        #3;
        reset   = 1'b1;
        lfsr_in = '0;
        reset_model();
        #1;
        exp_q.push_back(m_last);
        tag_q.push_back("async_reset_in_sync");
        check_out();
        #2 reset = 1'b0;
        @(posedge s2);
        #1;
        run(0, 56, -1);
        step(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
